// File: rtl/bus_rr_pkg.sv
// +----------------------------------------------------------------------+
// | bus_rr_pkg : FSM encodings shared by the round-robin bus and arbiter |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_rr_pkg;

  typedef logic [0:0] bus_state_t;

  localparam bus_state_t ST_IDLE  = 1'b0;
  localparam bus_state_t ST_OWNED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | bus_rr_arbiter : round-robin owner arbiter with burst-limit preempt  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_rr_arbiter
  import bus_rr_pkg::*;
#(
  parameter int N_MASTER  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_MASTER-1:0]         req_i,
  output logic [N_MASTER-1:0]         grant_o,
  output logic [$clog2(N_MASTER)-1:0] owner_o,
  output logic                        owned_o
);

  localparam int OW = $clog2(N_MASTER);
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  bus_state_t          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_MASTER-1:0] grant_q, grant_d;

  logic [N_MASTER-1:0] mask;
  logic [N_MASTER-1:0] pick_onehot;
  logic [OW-1:0]       base;
  logic [OW-1:0]       pick;
  logic                found;
  logic                sat;

  // While owned the current owner is excluded so the scan only sees competitors.
  always_comb begin
    if (state_q == ST_OWNED) begin
      base = owner_q;
      mask = req_i & ~({{(N_MASTER-1){1'b0}}, 1'b1} << owner_q);
    end else begin
      base = last_q;
      mask = req_i;
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= N_MASTER; i++) begin
      if (!found && mask[(int'(base) + i) % N_MASTER]) begin
        found = 1'b1;
        pick  = OW'((int'(base) + i) % N_MASTER);
      end
    end
  end

  assign pick_onehot = {{(N_MASTER-1){1'b0}}, 1'b1} << pick;
  assign sat         = (cnt_q == CW'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_OWNED;
          owner_d = pick;
          cnt_d   = CW'(1);
          grant_d = pick_onehot;
        end
      end
      default: begin
        if (!req_i[owner_q]) begin
          last_d = owner_q;
          if (found) begin
            owner_d = pick;
            cnt_d   = CW'(1);
            grant_d = pick_onehot;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            grant_d = '0;
          end
        end else if (MAX_BURST != 0 && sat && found) begin
          last_d  = owner_q;
          owner_d = pick;
          cnt_d   = CW'(1);
          grant_d = pick_onehot;
        end else if (MAX_BURST != 0 && !sat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(N_MASTER - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign owned_o = (state_q == ST_OWNED);

endmodule

`default_nettype wire

// File: rtl/bus_rr.sv
// +----------------------------------------------------------------------+
// | bus_rr   : N-master / M-slave shared bus, RR arbitration + decode    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_rr
  import bus_rr_pkg::*;
#(
  parameter int N_MASTER  = 4,
  parameter int N_SLAVE   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int REGION_W  = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_wr,
  input  logic [N_MASTER*ADDR_W-1:0]   m_address,
  input  logic [N_MASTER*DATA_W-1:0]   m_dout,
  output logic [N_MASTER-1:0]          m_grant,
  output logic [DATA_W-1:0]            m_din,
  output logic [N_SLAVE-1:0]           s_sel,
  output logic [ADDR_W-1:0]            s_address,
  output logic                         s_wr,
  output logic [DATA_W-1:0]            s_din,
  input  logic [N_SLAVE*DATA_W-1:0]    s_dout
);

  localparam int OW = $clog2(N_MASTER);
  localparam int RW = ADDR_W - REGION_W;

  logic [OW-1:0]      owner;
  logic               owned;
  logic [RW-1:0]      region;
  logic [N_SLAVE-1:0] rd_sel_q, rd_sel_d;

  bus_rr_arbiter #(
    .N_MASTER  (N_MASTER),
    .MAX_BURST (MAX_BURST)
  ) u_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (m_req),
    .grant_o (m_grant),
    .owner_o (owner),
    .owned_o (owned)
  );

  always_comb begin
    s_address = '0;
    s_wr      = 1'b0;
    s_din     = '0;
    if (owned) begin
      s_address = m_address[int'(owner)*ADDR_W +: ADDR_W];
      s_wr      = m_wr[owner];
      s_din     = m_dout[int'(owner)*DATA_W +: DATA_W];
    end
  end

  assign region = s_address[ADDR_W-1:REGION_W];

  // Regions at or above N_SLAVE match no select bit, so such accesses go nowhere.
  always_comb begin
    s_sel = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      s_sel[k] = owned && (int'(region) == k);
    end
  end

  assign rd_sel_d = s_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_q <= '0;
    end else begin
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    m_din = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      if (rd_sel_q[k]) begin
        m_din = m_din | s_dout[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_rr.sv
// +----------------------------------------------------------------------+
// | tb_bus_rr : scoreboard bench for the round-robin shared bus          |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bus_rr;

  localparam int K_GRANT = 0;
  localparam int K_SEL   = 1;
  localparam int K_WR    = 2;
  localparam int K_SDIN  = 3;
  localparam int K_MDIN  = 4;
  localparam int K_SADDR = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   m_req;
  logic [3:0]   m_wr;
  logic [31:0]  m_address;
  logic [127:0] m_dout;
  logic [3:0]   m_grant;
  logic [31:0]  m_din;
  logic [3:0]   s_sel;
  logic [7:0]   s_address;
  logic         s_wr;
  logic [31:0]  s_din;
  logic [127:0] s_dout;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] act;

  bus_rr #(
    .N_MASTER  (4),
    .N_SLAVE   (4),
    .ADDR_W    (8),
    .DATA_W    (32),
    .REGION_W  (5),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_address (m_address),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din),
    .s_sel     (s_sel),
    .s_address (s_address),
    .s_wr      (s_wr),
    .s_din     (s_din),
    .s_dout    (s_dout)
  );

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input int c, input int k, input logic [31:0] v, input string nm);
    exp_t x;
    x.cyc  = c;
    x.kind = k;
    x.exp  = v;
    x.nm   = nm;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample mid-cycle and retire every expectation due by now.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      case (e.kind)
        K_GRANT: act = {28'd0, m_grant};
        K_SEL:   act = {28'd0, s_sel};
        K_WR:    act = {31'd0, s_wr};
        K_SDIN:  act = s_din;
        K_MDIN:  act = m_din;
        default: act = {24'd0, s_address};
      endcase
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: sample for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", e.nm, cyc, act, e.exp);
      end
    end
  end

  initial begin
    int c;
    int n;
    reset_n   = 1'b0;
    m_req     = 4'hF;
    m_wr      = 4'h0;
    m_address = '0;
    m_dout    = '0;
    s_dout    = {32'h44, 32'h33, 32'h22, 32'h0A};

    // Reset held with every master requesting.
    repeat (3) step();
    c = cyc;
    chk(c, K_GRANT, 32'h0, "rst_grant");
    chk(c, K_SEL,   32'h0, "rst_sel");
    chk(c, K_WR,    32'h0, "rst_wr");
    chk(c, K_MDIN,  32'h0, "rst_mdin");

    // Release with 1111 held: four-cycle bursts rotating 0,1,2,3, then 0.
    step();
    c = cyc;
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk(c + 1 + i, K_GRANT, 32'(1 << ((i / 4) % 4)), "rr_rotate");
    end
    repeat (17) step();

    // Drop all requests: bus goes idle.
    n = cyc;
    m_req = 4'h0;
    chk(n + 1, K_GRANT, 32'h0, "idle_grant");
    chk(n + 1, K_SEL,   32'h0, "idle_sel");
    step();

    // m0 write to 0x21 -> slave 1.
    m_req            = 4'b0001;
    m_wr             = 4'b0001;
    m_address[7:0]   = 8'h21;
    m_dout[31:0]     = 32'h21;
    chk(n + 2, K_GRANT, 32'h1,  "wr_grant");
    chk(n + 2, K_SEL,   32'h2,  "wr_sel");
    chk(n + 2, K_WR,    32'h1,  "wr_wr");
    chk(n + 2, K_SDIN,  32'h21, "wr_sdin");
    chk(n + 2, K_SADDR, 32'h21, "wr_saddr");
    step();
    step();

    // m0 read 0x05 -> slave 0, data arrives a cycle after the select.
    m_wr           = 4'b0000;
    m_address[7:0] = 8'h05;
    chk(n + 3, K_SEL,  32'h1,  "rd_sel");
    chk(n + 3, K_WR,   32'h0,  "rd_wr");
    chk(n + 3, K_MDIN, 32'h22, "rd_prev_slave1");
    chk(n + 4, K_MDIN, 32'h0A, "rd_mdin");
    step();

    // Unmapped region 4.
    m_address[7:0] = 8'h80;
    m_wr           = 4'b0001;
    chk(n + 4, K_SEL,  32'h0, "unmapped_sel");
    chk(n + 5, K_MDIN, 32'h0, "unmapped_mdin");
    step();

    // m0 releases while m2 requests: handover on the same edge.
    m_req             = 4'b0100;
    m_wr              = 4'b0100;
    m_address[23:16]  = 8'h45;
    m_dout[95:64]     = 32'h5A;
    chk(n + 6, K_GRANT, 32'h4,  "handover_grant");
    chk(n + 6, K_SEL,   32'h4,  "handover_sel");
    chk(n + 6, K_SDIN,  32'h5A, "handover_sdin");
    chk(n + 6, K_SADDR, 32'h45, "handover_saddr");
    step();
    step();

    // Async reset pulse mid-cycle during the m2 burst.
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    chk(n + 7, K_GRANT, 32'h0, "async_rst_grant");
    chk(n + 7, K_SEL,   32'h0, "async_rst_sel");
    chk(n + 7, K_WR,    32'h0, "async_rst_wr");
    chk(n + 7, K_MDIN,  32'h0, "async_rst_mdin");
    chk(n + 8, K_GRANT, 32'h4, "post_rst_grant");

    for (int t = 0; t < 50 && sb.size() > 0; t++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
